// File: rtl/md5_add_pipe.sv
// Pipelined multi-operand mod-2^WIDTH adder tree plus MD5 chaining-state feed-forward bank.
// Optional macro MD5_ADD_PIPE_OUTREG_EN adds one output register stage after the last tree level.
module md5_add_pipe #(
    parameter int WIDTH     = 32,
    parameter int NUM_OPS   = 4,
    parameter int NUM_STATE = 4
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [NUM_OPS*WIDTH-1:0]   InOps,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [WIDTH-1:0]           OutSum,
    input  logic                       StateLoad,
    input  logic                       StateAccum,
    input  logic [NUM_STATE*WIDTH-1:0] StateIn,
    input  logic [NUM_STATE*WIDTH-1:0] WorkIn,
    output logic [NUM_STATE*WIDTH-1:0] StateOut,
    output logic                       AccumDone
);

    // Handshake: a set transfers on InValid & InReady; OutSum transfers on OutValid & OutReady.
    // The whole pipe advances together, so a stall freezes every level including bubbles.
    localparam int D = $clog2(NUM_OPS);

    logic                advance;
    logic [WIDTH-1:0]    src   [0:D-1][0:2*NUM_OPS-1];
    logic [WIDTH-1:0]    nxt   [0:D-1][0:NUM_OPS-1];
    logic [WIDTH-1:0]    lvl_q [0:D-1][0:NUM_OPS-1];
    logic [D-1:0]        vld_q;

    assign advance = OutReady | ~OutValid;
    assign InReady = advance;

    // Sources are zero-padded past each level's live word count, so an unpaired
    // odd word adds zero and passes through unchanged.
    always_comb begin
        for (int k = 0; k < D; k++) begin
            for (int i = 0; i < 2*NUM_OPS; i++) begin
                src[k][i] = '0;
            end
        end
        for (int i = 0; i < NUM_OPS; i++) begin
            src[0][i] = InOps[i*WIDTH +: WIDTH];
        end
        for (int k = 1; k < D; k++) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                src[k][i] = lvl_q[k-1][i];
            end
        end
        for (int k = 0; k < D; k++) begin
            for (int j = 0; j < NUM_OPS; j++) begin
                nxt[k][j] = src[k][2*j] + src[k][2*j+1];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_q <= '0;
            for (int k = 0; k < D; k++) begin
                for (int j = 0; j < NUM_OPS; j++) begin
                    lvl_q[k][j] <= '0;
                end
            end
        end else if (advance) begin
            vld_q[0] <= InValid;
            for (int k = 1; k < D; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            for (int k = 0; k < D; k++) begin
                for (int j = 0; j < NUM_OPS; j++) begin
                    lvl_q[k][j] <= nxt[k][j];
                end
            end
        end
    end

`ifdef MD5_ADD_PIPE_OUTREG_EN
    logic             out_vld_q;
    logic [WIDTH-1:0] out_sum_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_vld_q <= 1'b0;
            out_sum_q <= '0;
        end else if (advance) begin
            out_vld_q <= vld_q[D-1];
            out_sum_q <= lvl_q[D-1][0];
        end
    end

    assign OutValid = out_vld_q;
    assign OutSum   = out_sum_q;
`else
    assign OutValid = vld_q[D-1];
    assign OutSum   = lvl_q[D-1][0];
`endif

    // Feed-forward bank: load wins over accumulate; AccumDone marks a committed accumulate.
    logic [WIDTH-1:0] bank_q [0:NUM_STATE-1];
    logic             accum_done_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            accum_done_q <= 1'b0;
            for (int i = 0; i < NUM_STATE; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            accum_done_q <= StateAccum & ~StateLoad;
            for (int i = 0; i < NUM_STATE; i++) begin
                if (StateLoad) begin
                    bank_q[i] <= StateIn[i*WIDTH +: WIDTH];
                end else if (StateAccum) begin
                    bank_q[i] <= bank_q[i] + WorkIn[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_STATE; g++) begin : g_state_out
        assign StateOut[g*WIDTH +: WIDTH] = bank_q[g];
    end

    assign AccumDone = accum_done_q;

endmodule

// File: tb/tb_md5_add_pipe.sv
// Self-checking bench for md5_add_pipe: directed and random sums against a queue model,
// feed-forward bank checks, and mid-operation reset.
module tb_md5_add_pipe;

    localparam int W = 32;
    localparam int N = 4;
    localparam int S = 4;
`ifdef MD5_ADD_PIPE_OUTREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic           Clk = 1'b0;
    logic           Reset_n;
    logic           InValid;
    logic           InReady;
    logic [N*W-1:0] InOps;
    logic           OutValid;
    logic           OutReady;
    logic [W-1:0]   OutSum;
    logic           StateLoad;
    logic           StateAccum;
    logic [S*W-1:0] StateIn;
    logic [S*W-1:0] WorkIn;
    logic [S*W-1:0] StateOut;
    logic           AccumDone;

    int total = 0;
    int bad   = 0;

    logic [W-1:0]   exp_q[$];
    logic [N*W-1:0] sets[$];
    logic [W-1:0]   bank_m [S];

    md5_add_pipe #(.WIDTH(W), .NUM_OPS(N), .NUM_STATE(S)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .InValid   (InValid),
        .InReady   (InReady),
        .InOps     (InOps),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .OutSum    (OutSum),
        .StateLoad (StateLoad),
        .StateAccum(StateAccum),
        .StateIn   (StateIn),
        .WorkIn    (WorkIn),
        .StateOut  (StateOut),
        .AccumDone (AccumDone)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Reference: plain integer sum of all operands, reduced mod 2^W.
    function automatic logic [W-1:0] ref_sum(input logic [N*W-1:0] ops);
        longint unsigned s;
        s = 0;
        for (int i = 0; i < N; i++) s += longint'(ops[i*W +: W]);
        return W'(s % (64'd1 << W));
    endfunction

    function automatic logic [S*W-1:0] pack_bank();
        logic [S*W-1:0] p;
        for (int i = 0; i < S; i++) p[i*W +: W] = bank_m[i];
        return p;
    endfunction

    function automatic logic [N*W-1:0] rand_set();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = $urandom;
        return r;
    endfunction

    // mode 0: free flow, mode 1: OutReady low for cycles 3..6, mode 2: random valid/ready
    task automatic stream(input int mode);
        int           cyc;
        logic         stall_prev;
        logic [W-1:0] sum_prev;
        cyc = 0;
        stall_prev = 1'b0;
        sum_prev = '0;
        while ((sets.size() > 0 || exp_q.size() > 0) && cyc < 400) begin
            case (mode)
                0:       OutReady = 1'b1;
                1:       OutReady = !(cyc >= 3 && cyc < 7);
                default: OutReady = 1'($urandom_range(0, 1));
            endcase
            if (sets.size() > 0) begin
                InValid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
                InOps   = sets[0];
            end else begin
                InValid = 1'b0;
                InOps   = rand_set();
            end
            #1;
            if (stall_prev) begin
                chk("hold_valid", OutValid, 1'b1);
                chk("hold_sum", OutSum, sum_prev);
            end
            if (OutValid && !OutReady) chk("inready_stall", InReady, 1'b0);
            if (OutReady) chk("inready_open", InReady, 1'b1);
            if (OutValid && OutReady) begin
                if (exp_q.size() == 0) chk("extra_out", OutValid, 1'b0);
                else chk("sum", OutSum, exp_q.pop_front());
            end
            if (InValid && InReady) begin
                exp_q.push_back(ref_sum(sets[0]));
                void'(sets.pop_front());
            end
            stall_prev = OutValid && !OutReady;
            sum_prev   = OutSum;
            @(posedge Clk);
            #1;
            cyc++;
        end
        chk("drain", 128'(exp_q.size() + sets.size()), 128'd0);
        exp_q.delete();
        sets.delete();
        InValid  = 1'b0;
        OutReady = 1'b1;
    endtask

    task automatic bank_op(input logic ld, input logic acc,
                           input logic [S*W-1:0] sin, input logic [S*W-1:0] win);
        StateLoad  = ld;
        StateAccum = acc;
        StateIn    = sin;
        WorkIn     = win;
        step();
        StateLoad  = 1'b0;
        StateAccum = 1'b0;
        for (int i = 0; i < S; i++) begin
            if (ld) bank_m[i] = sin[i*W +: W];
            else if (acc) bank_m[i] = bank_m[i] + win[i*W +: W];
        end
        chk("state_out", StateOut, pack_bank());
        chk("accum_done", AccumDone, acc & ~ld);
    endtask

    initial begin
        logic [S*W-1:0] iv;
        logic [S*W-1:0] ones;

        Reset_n    = 1'b0;
        InValid    = 1'b0;
        InOps      = '0;
        OutReady   = 1'b1;
        StateLoad  = 1'b0;
        StateAccum = 1'b0;
        StateIn    = '0;
        WorkIn     = '0;
        for (int i = 0; i < S; i++) bank_m[i] = '0;

        step();
        step();
        chk("rst_outvalid", OutValid, 1'b0);
        chk("rst_outsum", OutSum, 32'd0);
        chk("rst_stateout", StateOut, 128'd0);
        chk("rst_accumdone", AccumDone, 1'b0);
        chk("rst_inready", InReady, 1'b1);
        Reset_n = 1'b1;
        step();

        // Latency: {1,2,3,4}, lane 0 = 1
        InOps   = {32'd4, 32'd3, 32'd2, 32'd1};
        InValid = 1'b1;
        step();
        InValid = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            chk("lat_valid", OutValid, (k == LAT));
            if (k == LAT) chk("lat_sum", OutSum, 32'h0000000A);
            else step();
        end
        step();
        chk("lat_drained", OutValid, 1'b0);

        // Wrap-around sets
        sets.push_back({32'h0, 32'h0, 32'h1, 32'hFFFFFFFF});
        sets.push_back({32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000});
        stream(0);

        // Backpressure: 5 sets, OutReady low cycles 3..6
        for (int i = 0; i < 5; i++) sets.push_back(rand_set());
        stream(1);

        // Random valid/ready traffic
        for (int i = 0; i < 30; i++) sets.push_back(rand_set());
        stream(2);

        // Bank: IV load then accumulate ones
        iv   = {32'h10325476, 32'h98BADCFE, 32'hEFCDAB89, 32'h67452301};
        ones = {32'd1, 32'd1, 32'd1, 32'd1};
        bank_op(1'b1, 1'b0, iv, '0);
        bank_op(1'b0, 1'b1, '0, ones);
        chk("iv_plus_one", StateOut, {32'h10325477, 32'h98BADCFF, 32'hEFCDAB8A, 32'h67452302});
        step();
        chk("accum_pulse_end", AccumDone, 1'b0);
        chk("bank_hold", StateOut, pack_bank());

        // Back-to-back accumulates with random work words
        for (int i = 0; i < 3; i++) bank_op(1'b0, 1'b1, '0, {$urandom, $urandom, $urandom, $urandom});

        // Load and accumulate together: load wins, no pulse
        bank_op(1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom}, ones);
        step();
        chk("idle_accumdone", AccumDone, 1'b0);

        // Reset with two sums in flight and a loaded bank
        bank_op(1'b1, 1'b0, iv, '0);
        OutReady = 1'b0;
        InOps    = rand_set();
        InValid  = 1'b1;
        step();
        InOps = rand_set();
        step();
        InValid = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_outvalid", OutValid, 1'b0);
        chk("mid_rst_stateout", StateOut, 128'd0);
        chk("mid_rst_accumdone", AccumDone, 1'b0);
        step();
        Reset_n  = 1'b1;
        OutReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst_no_stale", OutValid, 1'b0);
        end
        chk("post_rst_stateout", StateOut, 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
